game_flow_ctrl: RTL and testbench

Top-level game sequencer. It decides when the game runs, pauses after a player hit, advances waves, and ends the game. It issues the one-cycle reset pulses that clear the score/lives tracker and the invader field, and it gates movement logic via freeze. It sits between the input/debounce layer and the game datapath (score/lives tracker, invader grid, player, bullets).

---
 rtl/game_flow_ctrl.sv | 116 +++++++++++
 tb/tb_game_flow_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: start/play/hit/wave/over flow, reset pulses to the
// datapath, movement freeze and level tracking. All outputs are registered.
module game_flow_ctrl #(
    parameter int HIT_FRAMES  = 60,
    parameter int WAVE_FRAMES = 90,
    parameter int MAX_LEVEL   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       player_hit,
    input  logic [1:0] lives,
    input  logic       all_invaders_dead,
    input  logic       invaders_landed,
    output logic       game_rst,
    output logic       wave_rst,
    output logic       freeze,
    output logic       playing,
    output logic       game_over,
    output logic [2:0] level,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_HIT   = 3'd3;
    localparam logic [2:0] S_WAVE  = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    localparam logic [7:0] HIT_LAST  = 8'(HIT_FRAMES - 1);
    localparam logic [7:0] WAVE_LAST = 8'(WAVE_FRAMES - 1);
    localparam logic [2:0] LEVEL_MAX = 3'(MAX_LEVEL);

    logic       start_q;
    logic       start_press;
    logic [7:0] timer;
    logic [2:0] state_next;
    logic       hit_done;
    logic       wave_done;
    logic [2:0] level_next;

    assign start_press = start_btn & ~start_q;
    assign hit_done    = (state == S_HIT)  && frame_tick && (timer == HIT_LAST);
    assign wave_done   = (state == S_WAVE) && frame_tick && (timer == WAVE_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_press)
                    state_next = S_START;
            end
            S_START: state_next = S_PLAY;
            S_PLAY: begin
                if (invaders_landed)
                    state_next = S_OVER;
                else if (player_hit)
                    state_next = S_HIT;
                else if (all_invaders_dead)
                    state_next = S_WAVE;
            end
            S_HIT: begin
                // lives is sampled only at exit: the tracker decrements on the hit itself
                if (hit_done)
                    state_next = (lives == 2'd0) ? S_OVER : S_PLAY;
            end
            S_WAVE: begin
                if (wave_done)
                    state_next = S_PLAY;
            end
            S_OVER: begin
                if (start_press)
                    state_next = S_START;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        level_next = level;
        if (state_next == S_START)
            level_next = '0;
        else if (wave_done && (level < LEVEL_MAX))
            level_next = level + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b1;
            timer     <= '0;
            game_rst  <= 1'b0;
            wave_rst  <= 1'b0;
            freeze    <= 1'b1;
            playing   <= 1'b0;
            game_over <= 1'b0;
            level     <= '0;
        end else begin
            state     <= state_next;
            start_q   <= start_btn;
            level     <= level_next;
            game_rst  <= (state_next == S_START);
            wave_rst  <= (state_next == S_START) || wave_done;
            freeze    <= (state_next != S_PLAY);
            playing   <= (state_next == S_PLAY);
            game_over <= (state_next == S_OVER);
            if (state_next != state)
                timer <= '0;
            else if (frame_tick && ((state == S_HIT) || (state == S_WAVE)))
                timer <= timer + 8'd1;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short hit/wave freeze times.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       start_btn;
    logic       player_hit;
    logic [1:0] lives;
    logic       all_invaders_dead;
    logic       invaders_landed;
    logic       game_rst;
    logic       wave_rst;
    logic       freeze;
    logic       playing;
    logic       game_over;
    logic [2:0] level;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    game_flow_ctrl #(
        .HIT_FRAMES (3),
        .WAVE_FRAMES(2),
        .MAX_LEVEL  (7)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_tick       (frame_tick),
        .start_btn        (start_btn),
        .player_hit       (player_hit),
        .lives            (lives),
        .all_invaders_dead(all_invaders_dead),
        .invaders_landed  (invaders_landed),
        .game_rst         (game_rst),
        .wave_rst         (wave_rst),
        .freeze           (freeze),
        .playing          (playing),
        .game_over        (game_over),
        .level            (level),
        .state            (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_level;
        rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b1; player_hit = 1'b0;
        lives = 2'd2; all_invaders_dead = 1'b0; invaders_landed = 1'b0;
        step(); step();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_freeze", 8'(freeze), 8'd1);
        chk("rst_game_rst", 8'(game_rst), 8'd0);
        chk("rst_wave_rst", 8'(wave_rst), 8'd0);
        chk("rst_playing", 8'(playing), 8'd0);
        chk("rst_game_over", 8'(game_over), 8'd0);
        chk("rst_level", 8'(level), 8'd0);

        // button held through reset must not start the game
        rst = 1'b0;
        step(); step(); step();
        chk("held_btn_idle", 8'(state), 8'd0);
        start_btn = 1'b0;
        step();
        chk("release_idle", 8'(state), 8'd0);
        start_btn = 1'b1;
        step();
        chk("start_state", 8'(state), 8'd1);
        chk("start_game_rst", 8'(game_rst), 8'd1);
        chk("start_wave_rst", 8'(wave_rst), 8'd1);
        start_btn = 1'b0;
        step();
        chk("play_state", 8'(state), 8'd2);
        chk("play_playing", 8'(playing), 8'd1);
        chk("play_freeze", 8'(freeze), 8'd0);
        chk("play_game_rst_low", 8'(game_rst), 8'd0);
        chk("play_wave_rst_low", 8'(wave_rst), 8'd0);

        // hit with lives left: frozen for 3 ticks, second hit ignored
        player_hit = 1'b1;
        step();
        player_hit = 1'b0;
        chk("hit_state", 8'(state), 8'd3);
        chk("hit_freeze", 8'(freeze), 8'd1);
        chk("hit_playing", 8'(playing), 8'd0);
        tick();
        chk("hit_tick1", 8'(state), 8'd3);
        player_hit = 1'b1;
        step();
        player_hit = 1'b0;
        chk("hit_rehit_ignored", 8'(state), 8'd3);
        tick();
        chk("hit_tick2", 8'(state), 8'd3);
        chk("hit_tick2_freeze", 8'(freeze), 8'd1);
        tick();
        chk("hit_exit_play", 8'(state), 8'd2);
        chk("hit_exit_freeze", 8'(freeze), 8'd0);

        // first wave
        all_invaders_dead = 1'b1;
        step();
        all_invaders_dead = 1'b0;
        chk("wave_state", 8'(state), 8'd4);
        chk("wave_freeze", 8'(freeze), 8'd1);
        tick();
        chk("wave_tick1", 8'(state), 8'd4);
        chk("wave_tick1_wave_rst", 8'(wave_rst), 8'd0);
        tick();
        chk("wave_exit_state", 8'(state), 8'd2);
        chk("wave_exit_wave_rst", 8'(wave_rst), 8'd1);
        chk("wave_exit_game_rst", 8'(game_rst), 8'd0);
        chk("wave_level1", 8'(level), 8'd1);
        step();
        chk("wave_rst_one_cycle", 8'(wave_rst), 8'd0);

        // eight more waves: level saturates at 7
        exp_level = 1;
        for (int i = 0; i < 8; i++) begin
            all_invaders_dead = 1'b1;
            step();
            all_invaders_dead = 1'b0;
            tick(); tick();
            exp_level = (exp_level < 7) ? exp_level + 1 : 7;
            chk("wave_loop_level", 8'(level), 8'(exp_level));
        end
        chk("level_saturated", 8'(level), 8'd7);

        // landed wins over hit and dead
        invaders_landed = 1'b1; player_hit = 1'b1; all_invaders_dead = 1'b1;
        step();
        invaders_landed = 1'b0; player_hit = 1'b0; all_invaders_dead = 1'b0;
        chk("prio_over_state", 8'(state), 8'd5);
        chk("prio_game_over", 8'(game_over), 8'd1);
        chk("over_level_held", 8'(level), 8'd7);
        step();
        chk("over_stays", 8'(state), 8'd5);

        // new game from OVER
        start_btn = 1'b1;
        step();
        chk("restart_state", 8'(state), 8'd1);
        chk("restart_game_rst", 8'(game_rst), 8'd1);
        chk("restart_level", 8'(level), 8'd0);
        start_btn = 1'b0;
        step();
        chk("restart_play", 8'(state), 8'd2);

        // hit beats dead; lives drop to 0 during HIT -> OVER at exit
        player_hit = 1'b1; all_invaders_dead = 1'b1; lives = 2'd1;
        step();
        player_hit = 1'b0; all_invaders_dead = 1'b0; lives = 2'd0;
        chk("prio_hit_state", 8'(state), 8'd3);
        tick(); tick();
        chk("last_life_still_hit", 8'(state), 8'd3);
        tick();
        chk("last_life_over", 8'(state), 8'd5);
        chk("last_life_game_over", 8'(game_over), 8'd1);
        chk("last_life_playing", 8'(playing), 8'd0);

        start_btn = 1'b1;
        step();
        chk("restart2_game_rst", 8'(game_rst), 8'd1);
        chk("restart2_level", 8'(level), 8'd0);
        start_btn = 1'b0; lives = 2'd3;
        step();
        all_invaders_dead = 1'b1;
        step();
        all_invaders_dead = 1'b0;
        tick(); tick();
        chk("pre_rst_level", 8'(level), 8'd1);

        // reset mid-HIT
        player_hit = 1'b1;
        step();
        player_hit = 1'b0;
        tick();
        chk("pre_rst_hit", 8'(state), 8'd3);
        rst = 1'b1;
        step();
        chk("midrst_state", 8'(state), 8'd0);
        chk("midrst_level", 8'(level), 8'd0);
        chk("midrst_freeze", 8'(freeze), 8'd1);
        chk("midrst_game_rst", 8'(game_rst), 8'd0);
        chk("midrst_wave_rst", 8'(wave_rst), 8'd0);
        rst = 1'b0;
        step();
        chk("post_rst_idle", 8'(state), 8'd0);
        chk("post_rst_game_rst", 8'(game_rst), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
